clk_rst_seq: RTL and testbench
==============================

// Module: clk_rst_seq
// PURPOSE
//  Lock-qualified clock/reset sequencer that follows the vendor PLL wrapper. Synchronises the PLL
//  lock flag into refclk, debounces it, releases CHANNELS synchronous resets in staggered order,
//  and generates per-channel divided clock enables. It replaces ad-hoc per-core lock handling.
// PARAMETERS
//  CHANNELS     4                          number of reset/clock-enable channels (>=1)
//  DIV_W        8                          width of each divide ratio
//  DIVS         {8'd8,8'd4,8'd2,8'd1}      packed [CHANNELS*DIV_W-1:0]; slice i = divide ratio of ch i
//  SYNC_STAGES  2                          lock synchroniser depth (>=2)
//  SETTLE_CYC   1024                       consecutive locked cycles required before release (>=1)
//  RELEASE_GAP  16                         cycles between successive channel reset releases (>=1)
// PORTS
//  refclk      in   1         sole clock; all logic is in this domain
//  rst         in   1         asynchronous, active-high reset
//  pll_locked  in   1         raw PLL lock flag; asynchronous to refclk
//  locked      out  1         debounced lock; high only in RELEASE/RUN
//  rst_out     out  CHANNELS  per-channel synchronous active-high reset; bit 0 released first
//  ce          out  CHANNELS  per-channel clock enable; 1-cycle pulse every DIV_i cycles
//  lost_cnt    out  8         lock-loss event count (only with CLK_RST_SEQ_LOSS_CNT_EN)
// BEHAVIOUR
//  - Reset values: locked=0, rst_out=all 1, ce=0, lost_cnt=0, FSM=WAIT, all counters 0.
//  - lock_s = pll_locked after SYNC_STAGES flops (which reset to 0).
//  - FSM WAIT: settle cnt held 0; lock_s=1 -> SETTLE.
//  - FSM SETTLE: cnt++ each cycle while lock_s=1; lock_s=0 -> WAIT with cnt cleared (glitch restarts).
//    cnt==SETTLE_CYC-1 with lock_s=1 -> RELEASE; locked and rst_out[0] go low on that same edge.
//  - FSM RELEASE: gap cnt; rst_out[i] drops RELEASE_GAP cycles after rst_out[i-1]; after the last
//    channel releases -> RUN. CHANNELS=1 goes straight to RUN.
//  - FSM RUN: hold. Any state except WAIT with lock_s=0 -> WAIT on the next edge: rst_out=all 1,
//    ce=0, locked=0 (registered). Loss beats a release or gap expiry in the same cycle.
//  - Latency pll_locked rise -> locked: SYNC_STAGES+SETTLE_CYC cycles (+1 synchroniser uncertainty).
//  - Divider i: cnt_i held 0 and ce[i]=0 while rst_out[i]=1. After release, cnt_i counts 0..DIV_i-1
//    and wraps; registered ce[i]=1 in the cycle cnt_i==DIV_i-1, so the first pulse comes DIV_i cycles
//    after release. DIV_i of 0 or 1 -> ce[i] is constantly 1 once released.
//  - rst asserted mid-operation: all outputs take reset values immediately (async); sequence restarts.
//  - Counter widths come from $clog2 of the parameter; the settle count never wraps (saturates at terminal).
// CONFIGURATION
//  CLK_RST_SEQ_LOSS_CNT_EN defined: lost_cnt port exists. Increments once per RELEASE/RUN->WAIT
//    transition and saturates at 255. Cleared only by rst.
//  Not defined: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Package clk_rst_seq_pkg: state typedef {WAIT,SETTLE,RELEASE,RUN} (2 bits), LOSS_CNT_W=8,
//    and a helper returning the DIV_W slice of DIVS for channel i.
//  - Sub-module clk_div_ce (DIV_W, DIV): one divider counter plus registered ce. Generate-instanced
//    per channel, with clear = rst_out[i].
//  - The top level holds the synchroniser, FSM, settle/gap counters, rst_out register and loss counter.
// TESTING
//  1. SETTLE_CYC=16, RELEASE_GAP=4, SYNC=2, CHANNELS=4; pll_locked=1 at cycle 0 -> locked and
//     rst_out[0] low at cycle 18 (+-1), rst_out[1..3] low at 22, 26, 30.
//  2. In SETTLE at count 10, drop pll_locked for 1 cycle -> locked stays 0; release occurs 16 cycles
//     after lock_s returns high.
//  3. In RUN, drop pll_locked -> within SYNC_STAGES+1 cycles rst_out=4'hF, ce=0, locked=0; with the
//     macro, lost_cnt 0->1.
//  4. DIVS={4,3,1,2}, in RUN -> ce[0] every 2 cycles, ce[1] constant 1, ce[2] every 3, ce[3] every 4.
//     The first pulse comes DIV_i cycles after that channel's release.
//  5. Assert rst in RELEASE with 2 channels released -> same cycle rst_out=4'hF, locked=0, ce=0;
//     after deassert, a full WAIT->SETTLE sequence follows.
//  6. Macro on, 300 lock-loss events -> lost_cnt=255 (saturated); macro off -> builds with no
//     lost_cnt port.

Source files
------------

// File: rtl/clk_rst_seq_pkg.sv
// Shared types and helpers for the lock-qualified clock/reset sequencer.
// The state encoding, loss counter width and per-channel divide-ratio lookup
// live here so the top level and the divider agree on them.
package clk_rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    SETTLE  = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam int LOSS_CNT_W = 8;

  // Upper bound on the packed divide-ratio vector handed to div_of().
  localparam int DIVS_MAX_W = 1024;

  // Extract the div_w-bit divide ratio of channel ch from the packed vector.
  function automatic int unsigned div_of(input logic [DIVS_MAX_W-1:0] divs,
                                         input int div_w,
                                         input int ch);
    logic [DIVS_MAX_W-1:0] shifted;
    int unsigned           result;
    shifted = divs >> (ch * div_w);
    result  = 0;
    for (int b = 0; b < 32; b++) begin
      if (b < div_w) result[b] = shifted[b];
    end
    return result;
  endfunction

endpackage

// File: rtl/clk_rst_seq_div.sv
// Per-channel clock-enable divider. The counter is held at zero and the
// enable low while i_clear is high; once released it counts 0..DIV-1 and the
// registered enable pulses for one cycle each time the count wraps, so the
// first pulse lands DIV cycles after release. A ratio of 0 or 1 gives a
// constant enable.
module clk_div_ce #(
  parameter int          DIV_W = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_ce
);

  localparam int unsigned DIV_MAX = (32'd1 << DIV_W) - 32'd1;
  localparam int unsigned DIV_EFF = (DIV < 2) ? 1 : ((DIV > DIV_MAX) ? DIV_MAX : DIV);
  localparam int          CNT_W   = (DIV_EFF > 1) ? $clog2(DIV_EFF) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV_EFF - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ce;

  // Count while released and raise the enable on the cycle after the terminal count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else begin
      r_ce  <= (r_cnt == TERM);
      r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_ce = r_ce;

endmodule

// File: rtl/clk_rst_seq.sv
// Lock-qualified clock/reset sequencer. Synchronises the raw PLL lock flag,
// requires it to stay high for SETTLE_CYC consecutive cycles, then releases
// the per-channel synchronous resets one at a time RELEASE_GAP cycles apart.
// Each channel also gets a divided clock enable. Any loss of lock after
// WAIT throws every channel back into reset.
// Optional feature: define CLK_RST_SEQ_LOSS_CNT_EN to add the saturating
// lost_cnt port that counts lock-loss events out of RELEASE/RUN.
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int                      CHANNELS    = 4,
  parameter int                      DIV_W       = 8,
  parameter logic [CHANNELS*DIV_W-1:0] DIVS      = {8'd8, 8'd4, 8'd2, 8'd1},
  parameter int                      SYNC_STAGES = 2,
  parameter int                      SETTLE_CYC  = 1024,
  parameter int                      RELEASE_GAP = 16
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  locked,
  output logic [CHANNELS-1:0]   rst_out,
  output logic [CHANNELS-1:0]   ce
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] lost_cnt
`endif
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int GAP_W = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [SET_W-1:0] SET_TERM = SET_W'(SETTLE_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_TERM = GAP_W'(RELEASE_GAP - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lockS;
  state_t                 r_state;
  logic [SET_W-1:0]       r_settleCnt;
  logic [GAP_W-1:0]       r_gapCnt;
  logic [CH_W-1:0]        r_nextCh;
  logic                   r_locked;
  logic [CHANNELS-1:0]    r_rstOut;
  logic [CHANNELS-1:0]    w_ce;

  // Bring the asynchronous lock flag into refclk through a plain flop chain.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_lockS = r_sync[SYNC_STAGES-1];

  // Sequencer: debounce lock, then release resets in order; loss of lock wins over everything.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state     <= WAIT;
      r_settleCnt <= '0;
      r_gapCnt    <= '0;
      r_nextCh    <= '0;
      r_locked    <= 1'b0;
      r_rstOut    <= '1;
    end else if (!w_lockS) begin
      r_state     <= WAIT;
      r_settleCnt <= '0;
      r_gapCnt    <= '0;
      r_nextCh    <= '0;
      r_locked    <= 1'b0;
      r_rstOut    <= '1;
    end else begin
      case (r_state)
        WAIT: begin
          r_state     <= SETTLE;
          r_settleCnt <= '0;
        end
        SETTLE: begin
          if (r_settleCnt == SET_TERM) begin
            r_state     <= (CHANNELS == 1) ? RUN : RELEASE;
            r_locked    <= 1'b1;
            r_rstOut[0] <= 1'b0;
            r_gapCnt    <= '0;
            r_nextCh    <= CH_W'(1);
          end else begin
            r_settleCnt <= r_settleCnt + SET_W'(1);
          end
        end
        RELEASE: begin
          if (r_gapCnt == GAP_TERM) begin
            r_gapCnt           <= '0;
            r_rstOut[r_nextCh] <= 1'b0;
            r_nextCh           <= r_nextCh + CH_W'(1);
            if (r_nextCh == CH_LAST) begin
              r_state <= RUN;
            end
          end else begin
            r_gapCnt <= r_gapCnt + GAP_W'(1);
          end
        end
        RUN: begin
          r_state <= RUN;
        end
        default: begin
          r_state <= WAIT;
        end
      endcase
    end
  end

  assign locked  = r_locked;
  assign rst_out = r_rstOut;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_div
    clk_div_ce #(
      .DIV_W (DIV_W),
      .DIV   (div_of(DIVS_MAX_W'(DIVS), DIV_W, gi))
    ) u_div (
      .i_clk   (refclk),
      .i_rst   (rst),
      .i_clear (r_rstOut[gi]),
      .o_ce    (w_ce[gi])
    );
  end

  // Masking with the reset register drops every enable on the same edge that
  // a lock loss re-asserts the channel resets, rather than one cycle later.
  assign ce = w_ce & ~r_rstOut;

`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] r_lostCnt;
  logic                  w_lossEvent;

  assign w_lossEvent = !w_lockS && ((r_state == RELEASE) || (r_state == RUN));

  // Count lock losses out of RELEASE/RUN, saturating at all-ones.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_lostCnt <= '0;
    end else if (w_lossEvent && (r_lostCnt != {LOSS_CNT_W{1'b1}})) begin
      r_lostCnt <= r_lostCnt + LOSS_CNT_W'(1);
    end
  end

  assign lost_cnt = r_lostCnt;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq with SETTLE_CYC=16, RELEASE_GAP=4,
// SYNC_STAGES=2, CHANNELS=4 and divide ratios {4,3,1,2} (channel 3..0).
// Inputs change and outputs are sampled on the falling edge of refclk.
// Define CLK_RST_SEQ_LOSS_CNT_EN to also exercise lost_cnt.
module tb_clk_rst_seq;

  localparam int                CH     = 4;
  localparam int                SETTLE = 16;
  localparam int                GAP    = 4;
  localparam int                SYNC   = 2;
  localparam logic [CH*8-1:0]   DIVS_TB = {8'd4, 8'd3, 8'd1, 8'd2};
  localparam int                HIST   = 48;

  logic          refclk = 1'b0;
  logic          rst;
  logic          pllLocked;
  logic          locked;
  logic [CH-1:0] rstOut;
  logic [CH-1:0] ce;
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
  logic [7:0]    lostCnt;
`endif

  int nCompared   = 0;
  int nMismatched = 0;
  int divTb [CH]  = '{2, 1, 3, 4};

  logic [63:0] rstHist [CH];
  logic [63:0] ceHist  [CH];
  logic [63:0] lockHist;
  logic [63:0] expRst;
  logic [63:0] expCe;
  logic [63:0] expLock;
  int          r0;
  int          firstLock;
  int          relTime;

  always #5 refclk = ~refclk;

  clk_rst_seq #(
    .CHANNELS    (CH),
    .DIV_W       (8),
    .DIVS        (DIVS_TB),
    .SYNC_STAGES (SYNC),
    .SETTLE_CYC  (SETTLE),
    .RELEASE_GAP (GAP)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pllLocked),
    .locked     (locked),
    .rst_out    (rstOut),
    .ce         (ce)
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    ,
    .lost_cnt   (lostCnt)
`endif
  );

  // Drive both inputs of the sequencer at once.
  task automatic applyStimulus(input logic r, input logic p);
    rst       = r;
    pllLocked = p;
  endtask

  // Advance n rising edges, landing on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // One counted comparison; reports and counts on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b1, 1'b0);
    step(3);
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_rst_out", rstOut, 4'hF);
    checkOutput("reset_ce", ce, 0);
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    checkOutput("reset_lost_cnt", lostCnt, 0);
`endif

    // With no lock, the sequencer must sit in WAIT
    applyStimulus(1'b0, 1'b0);
    step(5);
    checkOutput("wait_rst_out", rstOut, 4'hF);
    checkOutput("wait_locked", locked, 0);

    // Test 1: lock from cycle 0, record the whole release and enable sequence
    for (int i = 0; i < CH; i++) begin
      rstHist[i] = '0;
      ceHist[i]  = '0;
    end
    lockHist  = '0;
    pllLocked = 1'b1;
    for (int k = 1; k <= HIST; k++) begin
      step(1);
      for (int i = 0; i < CH; i++) begin
        rstHist[i][k] = rstOut[i];
        ceHist[i][k]  = ce[i];
      end
      lockHist[k] = locked;
    end
    r0 = 0;
    for (int k = 1; k <= HIST; k++) begin
      if (r0 == 0 && rstHist[0][k] == 1'b0) r0 = k;
    end
    checkOutput("release0_latency_18or19", ((r0 == 18) || (r0 == 19)), 1);
    expLock = '0;
    for (int k = 1; k <= HIST; k++) expLock[k] = (r0 != 0) && (k >= r0);
    checkOutput("locked_history", lockHist, expLock);
    for (int i = 0; i < CH; i++) begin
      relTime = r0 + GAP * i;
      expRst  = '0;
      expCe   = '0;
      for (int k = 1; k <= HIST; k++) begin
        expRst[k] = (k < relTime);
        expCe[k]  = (k > relTime) && (((k - relTime) % divTb[i]) == 0);
      end
      checkOutput($sformatf("rst_out%0d_history", i), rstHist[i], expRst);
      checkOutput($sformatf("ce%0d_history", i), ceHist[i], expCe);
    end

    // Test 2: one-cycle lock glitch at settle count 10 restarts debounce
    applyStimulus(1'b1, 1'b0);
    step(2);
    applyStimulus(1'b0, 1'b1);
    step(13);
    pllLocked = 1'b0;
    step(1);
    pllLocked = 1'b1;
    firstLock = 0;
    for (int k = 15; k <= 60; k++) begin
      step(1);
      if (firstLock == 0 && locked == 1'b1) firstLock = k;
    end
    checkOutput("glitch_release_time", firstLock, r0 + 14);
    checkOutput("glitch_run_all_released", rstOut, 4'h0);

    // Test 3: lock loss in RUN
    pllLocked = 1'b0;
    step(SYNC + 1);
    checkOutput("loss_rst_out", rstOut, 4'hF);
    checkOutput("loss_ce", ce, 0);
    checkOutput("loss_locked", locked, 0);
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    checkOutput("loss_lost_cnt", lostCnt, 1);
`endif
    step(5);
    checkOutput("loss_holds_wait", rstOut, 4'hF);

    // Test 5: async reset in RELEASE with two channels released
    pllLocked = 1'b1;
    step(r0 + GAP + 1);
    checkOutput("two_released", rstOut, 4'hC);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_rst_out", rstOut, 4'hF);
    checkOutput("async_rst_locked", locked, 0);
    checkOutput("async_rst_ce", ce, 0);
`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    checkOutput("async_rst_lost_cnt", lostCnt, 0);
`endif
    step(2);
    rst       = 1'b0;
    firstLock = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (firstLock == 0 && locked == 1'b1) firstLock = k;
    end
    checkOutput("after_rst_full_sequence", firstLock, r0);

`ifdef CLK_RST_SEQ_LOSS_CNT_EN
    // Test 6: 300 lock losses saturate the counter
    for (int n = 0; n < 300; n++) begin
      pllLocked = 1'b0;
      step(SYNC + 2);
      pllLocked = 1'b1;
      step(r0 + 1);
    end
    checkOutput("lost_cnt_saturated", lostCnt, 255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
